// File: rtl/hazard_scoreboard.sv
// Stall and bypass control for a 5-stage pipeline, driven by the decoder's Tuse/Tnew hints.
// Shadow records for E/M/W carry only the fields that the stall and bypass decisions read.
module hazard_scoreboard #(
    parameter int REG_W = 5,
    parameter int T_W   = 3,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d_valid,
    input  logic [REG_W-1:0] d_rs,
    input  logic [REG_W-1:0] d_rt,
    input  logic [T_W-1:0]   d_rs_tuse,
    input  logic [T_W-1:0]   d_rt_tuse,
    input  logic [T_W-1:0]   d_tnew,
    input  logic             d_wr,
    input  logic [REG_W-1:0] d_dst,
    output logic             stall,
    output logic [1:0]       fwd_rs_d,
    output logic [1:0]       fwd_rt_d,
    output logic [1:0]       fwd_rs_e,
    output logic [1:0]       fwd_rt_e,
    output logic [1:0]       fwd_rt_m,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [T_W-1:0] TUSE_NONE = '1;

    logic             e_wr_q, e_wr_d;
    logic [REG_W-1:0] e_dst_q, e_dst_d, e_rs_q, e_rs_d, e_rt_q, e_rt_d;
    logic [T_W-1:0]   e_tnew_q, e_tnew_d;
    logic             m_wr_q, m_wr_d;
    logic [REG_W-1:0] m_dst_q, m_dst_d, m_rt_q, m_rt_d;
    logic [T_W-1:0]   m_tnew_q, m_tnew_d;
    logic             w_wr_q, w_wr_d;
    logic [REG_W-1:0] w_dst_q, w_dst_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic e_live, m_live, w_live;

    assign e_live = e_wr_q && (e_dst_q != '0);
    assign m_live = m_wr_q && (m_dst_q != '0);
    assign w_live = w_wr_q && (w_dst_q != '0);

    function automatic logic [T_W-1:0] sat_dec(input logic [T_W-1:0] x);
        return (x != '0) ? x - 1'b1 : '0;
    endfunction

    // Only the youngest matching writer counts; an older copy of the same register is stale.
    function automatic logic src_hazard(input logic [REG_W-1:0] src, input logic [T_W-1:0] tuse);
        if (!d_valid || tuse == TUSE_NONE || src == '0) return 1'b0;
        if (e_live && e_dst_q == src) return e_tnew_q > tuse;
        if (m_live && m_dst_q == src) return m_tnew_q > tuse;
        return 1'b0;
    endfunction

    function automatic logic [1:0] sel_d(input logic [REG_W-1:0] src);
        if (e_live && e_dst_q == src) return (e_tnew_q == '0) ? 2'd1 : 2'd0;
        if (m_live && m_dst_q == src) return (m_tnew_q == '0) ? 2'd2 : 2'd0;
        if (w_live && w_dst_q == src) return 2'd3;
        return 2'd0;
    endfunction

    function automatic logic [1:0] sel_e(input logic [REG_W-1:0] src);
        if (m_live && m_dst_q == src) return (m_tnew_q == '0) ? 2'd2 : 2'd0;
        if (w_live && w_dst_q == src) return 2'd3;
        return 2'd0;
    endfunction

    function automatic logic [1:0] sel_m(input logic [REG_W-1:0] src);
        return (w_live && w_dst_q == src) ? 2'd3 : 2'd0;
    endfunction

    always_comb begin
        stall    = src_hazard(d_rs, d_rs_tuse) | src_hazard(d_rt, d_rt_tuse);
        fwd_rs_d = sel_d(d_rs);
        fwd_rt_d = sel_d(d_rt);
        fwd_rs_e = sel_e(e_rs_q);
        fwd_rt_e = sel_e(e_rt_q);
        fwd_rt_m = sel_m(m_rt_q);
    end

    assign stall_cnt = stall_cnt_q;

    // W is always forwardable, so its remaining latency is not stored.
    always_comb begin
        w_wr_d   = m_wr_q;
        w_dst_d  = m_dst_q;
        m_wr_d   = e_wr_q;
        m_dst_d  = e_dst_q;
        m_rt_d   = e_rt_q;
        m_tnew_d = sat_dec(e_tnew_q);
        e_wr_d   = 1'b0;
        e_dst_d  = '0;
        e_rs_d   = '0;
        e_rt_d   = '0;
        e_tnew_d = '0;
        if (d_valid && !stall) begin
            e_wr_d   = d_wr;
            e_dst_d  = d_dst;
            e_rs_d   = d_rs;
            e_rt_d   = d_rt;
            e_tnew_d = sat_dec(d_tnew);
        end
        stall_cnt_d = stall ? stall_cnt_q + 1'b1 : stall_cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_wr_q      <= 1'b0;
            e_dst_q     <= '0;
            e_rs_q      <= '0;
            e_rt_q      <= '0;
            e_tnew_q    <= '0;
            m_wr_q      <= 1'b0;
            m_dst_q     <= '0;
            m_rt_q      <= '0;
            m_tnew_q    <= '0;
            w_wr_q      <= 1'b0;
            w_dst_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            e_wr_q      <= e_wr_d;
            e_dst_q     <= e_dst_d;
            e_rs_q      <= e_rs_d;
            e_rt_q      <= e_rt_d;
            e_tnew_q    <= e_tnew_d;
            m_wr_q      <= m_wr_d;
            m_dst_q     <= m_dst_d;
            m_rt_q      <= m_rt_d;
            m_tnew_q    <= m_tnew_d;
            w_wr_q      <= w_wr_d;
            w_dst_q     <= w_dst_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenario table, mid-stall reset, and random
// instruction streams checked against a ready-time model of the in-flight writers.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        d_valid, d_wr;
    logic [4:0]  d_rs, d_rt, d_dst;
    logic [2:0]  d_rs_tuse, d_rt_tuse, d_tnew;
    logic        stall;
    logic [1:0]  fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m;
    logic [31:0] stall_cnt;

    hazard_scoreboard #(.REG_W(5), .T_W(3), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
        .d_rs_tuse(d_rs_tuse), .d_rt_tuse(d_rt_tuse), .d_tnew(d_tnew), .d_wr(d_wr),
        .d_dst(d_dst), .stall(stall), .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
        .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e), .fwd_rt_m(fwd_rt_m), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [4:0] rs, rt;
        logic [2:0] rs_tuse, rt_tuse, tnew;
        logic       wr;
        logic [4:0] dst;
    } din_t;

    typedef struct {
        logic        rst;
        din_t        in;
        logic        stall;
        logic [1:0]  rs_d, rt_d, rs_e, rt_e, rt_m;
        int unsigned cnt;
    } vec_t;

    // In-flight writer: ready = absolute cycle from which its result is forwardable.
    typedef struct {
        logic       live;
        logic [4:0] dst, rs, rt;
        int         ready;
    } rec_t;

    rec_t        pipe [3];
    int          cyc;
    int unsigned m_cnt;
    int          n_tests = 0;
    int          n_fail  = 0;
    vec_t        vecs[$];

    function automatic din_t mk(logic v, logic [4:0] rs, logic [4:0] rt, logic [2:0] ut_rs,
                                logic [2:0] ut_rt, logic [2:0] tn, logic wr, logic [4:0] dst);
        din_t d;
        d.valid = v; d.rs = rs; d.rt = rt; d.rs_tuse = ut_rs; d.rt_tuse = ut_rt;
        d.tnew = tn; d.wr = wr; d.dst = dst;
        return d;
    endfunction

    function automatic vec_t mv(logic r, din_t i, logic s, logic [1:0] a, logic [1:0] b,
                                logic [1:0] c, logic [1:0] e, logic [1:0] m, int unsigned n);
        vec_t v;
        v.rst = r; v.in = i; v.stall = s; v.rs_d = a; v.rt_d = b;
        v.rs_e = c; v.rt_e = e; v.rt_m = m; v.cnt = n;
        return v;
    endfunction

    task automatic apply(input din_t i);
        d_valid = i.valid; d_rs = i.rs; d_rt = i.rt; d_rs_tuse = i.rs_tuse;
        d_rt_tuse = i.rt_tuse; d_tnew = i.tnew; d_wr = i.wr; d_dst = i.dst;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---- reference model ----
    function automatic int rem(int k);
        if (k == 2) return 0;
        return (pipe[k].ready > cyc) ? pipe[k].ready - cyc : 0;
    endfunction

    function automatic int find(logic [4:0] src, int from);
        for (int k = from; k < 3; k++)
            if (pipe[k].live && pipe[k].dst == src) return k;
        return -1;
    endfunction

    function automatic logic m_haz(din_t i, logic [4:0] src, logic [2:0] tuse);
        int k;
        if (!i.valid || tuse == 3'd7 || src == 5'd0) return 1'b0;
        k = find(src, 0);
        return (k >= 0) && (rem(k) > int'(tuse));
    endfunction

    function automatic logic [1:0] m_fwd(logic [4:0] src, int from);
        int k;
        k = find(src, from);
        if (k < 0 || rem(k) != 0) return 2'd0;
        return 2'(k + 1);
    endfunction

    function automatic vec_t m_expect(din_t i);
        vec_t e;
        e.rst   = 1'b0;
        e.in    = i;
        e.stall = m_haz(i, i.rs, i.rs_tuse) | m_haz(i, i.rt, i.rt_tuse);
        e.rs_d  = m_fwd(i.rs, 0);
        e.rt_d  = m_fwd(i.rt, 0);
        e.rs_e  = m_fwd(pipe[0].rs, 1);
        e.rt_e  = m_fwd(pipe[0].rt, 1);
        e.rt_m  = m_fwd(pipe[1].rt, 2);
        e.cnt   = m_cnt;
        return e;
    endfunction

    task automatic model_tick(input din_t i, input logic st);
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        if (st || !i.valid) pipe[0] = '{1'b0, 5'd0, 5'd0, 5'd0, 0};
        else pipe[0] = '{i.wr && (i.dst != 5'd0), i.dst, i.rs, i.rt, cyc + int'(i.tnew)};
        cyc++;
        if (st) m_cnt++;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) pipe[k] = '{1'b0, 5'd0, 5'd0, 5'd0, 0};
        m_cnt = 0;
    endtask

    task automatic check_all(input string tag, input vec_t e);
        chk({tag, "/stall"},    32'(stall),     32'(e.stall));
        chk({tag, "/fwd_rs_d"}, 32'(fwd_rs_d),  32'(e.rs_d));
        chk({tag, "/fwd_rt_d"}, 32'(fwd_rt_d),  32'(e.rt_d));
        chk({tag, "/fwd_rs_e"}, 32'(fwd_rs_e),  32'(e.rs_e));
        chk({tag, "/fwd_rt_e"}, 32'(fwd_rt_e),  32'(e.rt_e));
        chk({tag, "/fwd_rt_m"}, 32'(fwd_rt_m),  32'(e.rt_m));
        chk({tag, "/stall_cnt"}, stall_cnt,     e.cnt);
    endtask

    // Drive D, check mid-cycle, clock once; the model advances on its own stall decision.
    task automatic cycle(input din_t i, input string tag, input logic use_tv, input vec_t tv,
                         output logic st);
        vec_t m;
        apply(i);
        #2;
        m = m_expect(i);
        check_all(tag, use_tv ? tv : m);
        st = m.stall;
        @(posedge clk);
        model_tick(i, m.stall);
        #1;
    endtask

    din_t NOP, LW1, ADD2, BEQ1, ADD3, BEQ33, SW, JAL, JR, ORI0, BEQ00, ORI5, ADD6;
    vec_t ZERO;

    task automatic do_reset(input logic check_now);
        reset = 1'b1;
        #1;
        if (check_now) begin
            ZERO.cnt = 0;
            check_all("reset", ZERO);
        end
        model_reset();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        logic st, prev_st;
        int   s2_lo, s2_hi;
        din_t cur;
        vec_t dummy;
        logic [2:0] tuse_pick [4];
        logic [2:0] tnew_pick [4];

        NOP   = mk(0, 0, 0, 7, 7, 0, 0, 0);
        LW1   = mk(1, 0, 0, 1, 7, 3, 1, 1);
        ADD2  = mk(1, 1, 1, 1, 1, 2, 1, 2);
        BEQ1  = mk(1, 1, 0, 0, 0, 0, 0, 0);
        ADD3  = mk(1, 0, 0, 1, 1, 2, 1, 3);
        BEQ33 = mk(1, 3, 3, 0, 0, 0, 0, 0);
        SW    = mk(1, 4, 3, 1, 2, 0, 0, 0);
        JAL   = mk(1, 0, 0, 7, 7, 0, 1, 31);
        JR    = mk(1, 31, 0, 0, 7, 0, 0, 0);
        ORI0  = mk(1, 0, 0, 1, 7, 2, 1, 0);
        BEQ00 = mk(1, 0, 0, 0, 0, 0, 0, 0);
        ORI5  = mk(1, 0, 0, 1, 7, 2, 1, 5);
        ADD6  = mk(1, 5, 5, 1, 1, 2, 1, 6);
        ZERO  = mv(0, NOP, 0, 0, 0, 0, 0, 0, 0);
        dummy = ZERO;
        cyc   = 0;

        // lw -> add
        vecs.push_back(mv(1, LW1,  0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mv(0, ADD2, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mv(0, ADD2, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mv(0, NOP,  0, 0, 0, 3, 3, 0, 1));
        // lw -> beq
        s2_lo = vecs.size();
        vecs.push_back(mv(1, LW1,  0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mv(0, BEQ1, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mv(0, BEQ1, 1, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mv(0, BEQ1, 0, 3, 0, 0, 0, 0, 2));
        vecs.push_back(mv(0, NOP,  0, 0, 0, 0, 0, 0, 2));
        s2_hi = vecs.size();
        // add -> beq, add -> sw
        vecs.push_back(mv(1, ADD3,  0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mv(0, BEQ33, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mv(0, BEQ33, 0, 2, 2, 0, 0, 0, 1));
        vecs.push_back(mv(0, ADD3,  0, 0, 0, 3, 3, 0, 1));
        vecs.push_back(mv(0, SW,    0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mv(0, NOP,   0, 0, 0, 0, 2, 0, 1));
        vecs.push_back(mv(0, NOP,   0, 0, 0, 0, 0, 3, 1));
        // jal -> jr, writes to $0
        vecs.push_back(mv(1, JAL,   0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mv(0, JR,    0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mv(0, ORI0,  0, 0, 0, 2, 0, 0, 0));
        vecs.push_back(mv(0, BEQ00, 0, 0, 0, 0, 0, 0, 0));
        // youngest of two writers wins
        vecs.push_back(mv(1, ORI5,  0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mv(0, ORI5,  0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mv(0, ADD6,  0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mv(0, NOP,   0, 0, 0, 2, 2, 0, 0));
        vecs.push_back(mv(0, NOP,   0, 0, 0, 0, 0, 3, 0));

        reset = 1'b1;
        apply(NOP);
        #12;
        check_all("por", ZERO);
        model_reset();
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int k = 0; k < vecs.size(); k++) begin
            if (vecs[k].rst) do_reset(1'b0);
            cycle(vecs[k].in, $sformatf("vec%0d", k), 1'b1, vecs[k], st);
        end

        // reset while lw -> beq is stalled
        do_reset(1'b1);
        cycle(LW1,  "s6a", 1'b0, dummy, st);
        cycle(BEQ1, "s6b", 1'b0, dummy, st);
        apply(BEQ1);
        #2;
        chk("s6 pre-reset stall", 32'(stall), 32'd1);
        chk("s6 pre-reset cnt", stall_cnt, 32'd1);
        reset = 1'b1;
        #1;
        ZERO.cnt = 0;
        check_all("s6 in-reset", ZERO);
        model_reset();
        reset = 1'b0;
        #1;
        chk("s6 post-release stall", 32'(stall), 32'd0);
        @(posedge clk);
        model_tick(BEQ1, 1'b0);
        #1;
        for (int k = s2_lo; k < s2_hi; k++) begin
            if (vecs[k].rst) do_reset(1'b0);
            cycle(vecs[k].in, $sformatf("replay%0d", k), 1'b1, vecs[k], st);
        end

        // random instruction stream; a stalled instruction usually stays in D
        tuse_pick[0] = 3'd0; tuse_pick[1] = 3'd1; tuse_pick[2] = 3'd2; tuse_pick[3] = 3'd7;
        tnew_pick[0] = 3'd0; tnew_pick[1] = 3'd2; tnew_pick[2] = 3'd3; tnew_pick[3] = 3'd1;
        do_reset(1'b1);
        prev_st = 1'b0;
        cur = NOP;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) do_reset(1'b1);
            if (!(prev_st && $urandom_range(0, 3) != 0)) begin
                cur.valid   = ($urandom_range(0, 7) != 0);
                cur.rs      = 5'($urandom_range(0, 3));
                cur.rt      = 5'($urandom_range(0, 3));
                cur.rs_tuse = tuse_pick[$urandom_range(0, 3)];
                cur.rt_tuse = tuse_pick[$urandom_range(0, 3)];
                cur.tnew    = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7))
                                                          : tnew_pick[$urandom_range(0, 2)];
                cur.wr      = ($urandom_range(0, 3) != 0);
                cur.dst     = 5'($urandom_range(0, 3));
            end
            cycle(cur, "rand", 1'b0, dummy, st);
            prev_st = st;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
